radiant_wb_arbiter: RTL and testbench

Two-master WISHBONE classic arbiter that shares the single register-space slave bus between masters.
- Master 0: the board-manager UART bridge.
- Master 1: a second host, e.g. the SPI/controller bridge.

It grants the bus round-robin, muxes the winner onto the slave bus, and forwards the termination. A bus-timeout watchdog terminates hung cycles with an error so no master can stall the register space forever. It sits between the bus masters and the register decode logic, all on the 50 MHz control clock.

---
 rtl/radiant_wb_pkg.sv | 22 ++
 rtl/radiant_wb_arbiter_watchdog.sv | 45 ++++
 rtl/radiant_wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_radiant_wb_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radiant_wb_pkg.sv
// Shared widths, arbiter state encoding and helpers for the register-bus arbiter.
package radiant_wb_pkg;

    localparam int unsigned WB_ADDR_W  = 20;
    localparam int unsigned WB_DATA_W  = 32;
    localparam int unsigned WB_SEL_W   = 4;
    localparam int unsigned WD_CNT_W   = 16;
    localparam int unsigned TOUT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_TOUT = 2'd3
    } arb_state_e;

    // Increment that sticks at the all-ones value.
    function automatic logic [TOUT_CNT_W-1:0] sat_inc(input logic [TOUT_CNT_W-1:0] v);
        return (v == {TOUT_CNT_W{1'b1}}) ? v : v + TOUT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/radiant_wb_arbiter_watchdog.sv
// Bus-timeout watchdog: counts stalled strobe cycles and flags a hung transfer.
module wb_bus_watchdog
    import radiant_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = WD_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  stb,
    input  logic                  term,
    input  logic                  tout,
    output logic                  expire_c,
    output logic [TOUT_CNT_W-1:0] timeout_count
);

    logic [CNT_W-1:0] cnt_q;
    logic             stalled_c;

    assign stalled_c = active & stb & ~term;
    // A transfer that terminates in the compare cycle is not treated as hung.
    assign expire_c  = stalled_c && (cnt_q == CNT_W'(TIMEOUT));

    // Stall counter: clears on termination, dropped strobe, idle bus or expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!stalled_c || expire_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Saturating count of forced terminations since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_count <= '0;
        end else if (tout) begin
            timeout_count <= sat_inc(timeout_count);
        end
    end

endmodule

// File: rtl/radiant_wb_arbiter.sv
// Two-master round-robin WISHBONE classic arbiter with bus-timeout watchdog.
module radiant_wb_arbiter
    import radiant_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
    parameter int unsigned DATA_WIDTH = WB_DATA_W,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [ADDR_WIDTH-1:0]     m0_adr_i,
    input  logic [DATA_WIDTH-1:0]     m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    output logic                      m0_rty_o,
    output logic [DATA_WIDTH-1:0]     m0_dat_o,
    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [ADDR_WIDTH-1:0]     m1_adr_i,
    input  logic [DATA_WIDTH-1:0]     m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    output logic                      m1_rty_o,
    output logic [DATA_WIDTH-1:0]     m1_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDR_WIDTH-1:0]     s_adr_o,
    output logic [DATA_WIDTH-1:0]     s_dat_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    input  logic [DATA_WIDTH-1:0]     s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    output logic [TOUT_CNT_W-1:0]     timeout_count_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_grant_q;
    logic       req0_c;
    logic       req1_c;
    logic       own_c;
    logic       own_stb_c;
    logic       term_c;
    logic       expire_c;

    assign req0_c = m0_cyc_i & m0_stb_i;
    assign req1_c = m1_cyc_i & m1_stb_i;
    assign own_c  = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign term_c = s_ack_i | s_err_i | s_rty_i;

    // Owner strobe computed apart from the output mux so the watchdog sees no loop.
    assign own_stb_c = (state_q == ST_OWN0) ? m0_stb_i :
                       (state_q == ST_OWN1) ? m1_stb_i : 1'b0;

    // Read data is broadcast; only the terminated master consumes it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    wb_bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (WD_CNT_W)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .active        (own_c),
        .stb           (own_stb_c),
        .term          (term_c),
        .tout          (state_q == ST_TOUT),
        .expire_c      (expire_c),
        .timeout_count (timeout_count_o)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round-robin history: remembers the master granted most recently.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (state_q == ST_IDLE && state_d == ST_OWN0) begin
            last_grant_q <= 1'b0;
        end else if (state_q == ST_IDLE && state_d == ST_OWN1) begin
            last_grant_q <= 1'b1;
        end
    end

    // Next-state decode plus bus mux and termination routing.
    always_comb begin
        state_d  = state_q;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0_c && req1_c) begin
                    state_d = last_grant_q ? ST_OWN0 : ST_OWN1;
                end else if (req0_c) begin
                    state_d = ST_OWN0;
                end else if (req1_c) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
                m0_rty_o = s_rty_i;
                if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (expire_c) begin
                    state_d = ST_TOUT;
                end
            end
            ST_OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
                m1_rty_o = s_rty_i;
                if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (expire_c) begin
                    state_d = ST_TOUT;
                end
            end
            ST_TOUT: begin
                // Slave is cut off; the owner gets a forced error, late acks are dropped.
                m0_err_o = ~last_grant_q;
                m1_err_o = last_grant_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_radiant_wb_arbiter.sv
// Directed self-checking bench for the two-master WISHBONE arbiter.
module tb_radiant_wb_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    localparam logic [AW-1:0] M0_ADR = 20'h00001;
    localparam logic [DW-1:0] M0_DAT = 32'hDEADBEEF;
    localparam logic [SW-1:0] M0_SEL = 4'hF;
    localparam logic [AW-1:0] M1_ADR = 20'hABCDE;
    localparam logic [DW-1:0] M1_DAT = 32'h0BADF00D;
    localparam logic [SW-1:0] M1_SEL = 4'h3;

    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic          clk;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat;
    logic [SW-1:0] m0_sel;
    logic          m0_ack, m0_err, m0_rty;
    logic [DW-1:0] m0_rdat;
    logic          m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat;
    logic [SW-1:0] m1_sel;
    logic          m1_ack, m1_err, m1_rty;
    logic [DW-1:0] m1_rdat;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_rdat;
    logic          s_ack, s_err, s_rty;
    logic [7:0]    tcnt;

    // Second instance with a short timeout, used only for saturation.
    logic          f_req;
    logic          f_m0_ack, f_m0_err, f_m0_rty, f_m1_ack, f_m1_err, f_m1_rty;
    logic [DW-1:0] f_m0_rdat, f_m1_rdat, f_s_wdat;
    logic          f_s_cyc, f_s_stb, f_s_we;
    logic [AW-1:0] f_s_adr;
    logic [SW-1:0] f_s_sel;
    logic [7:0]    f_tcnt;

    int n_tests;
    int n_fail;

    typedef struct {
        logic          rst;
        logic          r0;
        logic          r1;
        logic [2:0]    term;   // {rty, err, ack}
        logic [DW-1:0] sdat;
        logic          e_cyc;
        logic [1:0]    e_own;
        logic [2:0]    e_t0;
        logic [2:0]    e_t1;
    } vec_t;

    vec_t tbl[$];

    radiant_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(255)) u_dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m0_rty_o(m0_rty), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m1_rty_o(m1_rty), .m1_dat_o(m1_rdat),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_dat_i(s_rdat),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .timeout_count_o(tcnt)
    );

    radiant_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(2)) u_dut_fast (
        .clk(clk), .rst(rst),
        .m0_cyc_i(f_req), .m0_stb_i(f_req), .m0_we_i(1'b1), .m0_adr_i(M0_ADR),
        .m0_dat_i(M0_DAT), .m0_sel_i(M0_SEL), .m0_ack_o(f_m0_ack), .m0_err_o(f_m0_err),
        .m0_rty_o(f_m0_rty), .m0_dat_o(f_m0_rdat),
        .m1_cyc_i(1'b0), .m1_stb_i(1'b0), .m1_we_i(1'b0), .m1_adr_i(M1_ADR),
        .m1_dat_i(M1_DAT), .m1_sel_i(M1_SEL), .m1_ack_o(f_m1_ack), .m1_err_o(f_m1_err),
        .m1_rty_o(f_m1_rty), .m1_dat_o(f_m1_rdat),
        .s_cyc_o(f_s_cyc), .s_stb_o(f_s_stb), .s_we_o(f_s_we), .s_adr_o(f_s_adr),
        .s_dat_o(f_s_wdat), .s_sel_o(f_s_sel), .s_dat_i(32'h0),
        .s_ack_i(1'b0), .s_err_i(1'b0), .s_rty_i(1'b0),
        .timeout_count_o(f_tcnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic r0, input logic r1);
        m0_cyc = r0; m0_stb = r0;
        m1_cyc = r1; m1_stb = r1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(1'b0, 1'b0);
        {s_rty, s_err, s_ack} = 3'b000;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t v(input logic rs, input logic r0, input logic r1,
                               input logic [2:0] term, input logic [DW-1:0] sdat,
                               input logic e_cyc, input logic [1:0] e_own,
                               input logic [2:0] e_t0, input logic [2:0] e_t1);
        vec_t x;
        x.rst = rs; x.r0 = r0; x.r1 = r1; x.term = term; x.sdat = sdat;
        x.e_cyc = e_cyc; x.e_own = e_own; x.e_t0 = e_t0; x.e_t1 = e_t1;
        return x;
    endfunction

    initial begin
        logic          e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        logic          early_err;
        int            exp_cnt;

        n_tests = 0;
        n_fail  = 0;
        m0_we = 1'b1; m0_adr = M0_ADR; m0_dat = M0_DAT; m0_sel = M0_SEL;
        m1_we = 1'b0; m1_adr = M1_ADR; m1_dat = M1_DAT; m1_sel = M1_SEL;
        s_rdat = '0;
        f_req  = 1'b0;
        do_reset();

        chk("reset s_cyc", {63'd0, s_cyc}, 64'd0);
        chk("reset acks", {62'd0, m0_ack, m1_ack}, 64'd0);
        chk("reset tcnt", {56'd0, tcnt}, 64'd0);

        // rst r0 r1 term sdat         cyc own   t0     t1
        tbl.push_back(v(0, 1, 0, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 0, 3'b000, 32'h0,        1, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 0, 3'b000, 32'h0,        1, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 0, 3'b001, 32'hAAAA5555, 1, OWN0, 3'b001, 3'b000));
        tbl.push_back(v(0, 0, 0, 3'b000, 32'h0,        0, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 0, 0, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(1, 0, 0, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b000, 32'h0,        1, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b001, 32'h11112222, 1, OWN0, 3'b001, 3'b000));
        tbl.push_back(v(0, 0, 1, 3'b000, 32'h0,        0, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 0, 1, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b000, 32'h0,        1, OWN1, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b100, 32'h0,        1, OWN1, 3'b000, 3'b100));
        tbl.push_back(v(0, 1, 0, 3'b000, 32'h0,        0, OWN1, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b000, 32'h0,        1, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b011, 32'h33334444, 1, OWN0, 3'b011, 3'b000));
        tbl.push_back(v(0, 0, 1, 3'b000, 32'h0,        0, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 0, 1, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 0, 0, 3'b000, 32'h0,        0, OWN1, 3'b000, 3'b000));
        tbl.push_back(v(0, 0, 0, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 0, 1, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b000, 32'h0,        1, OWN1, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 1, 3'b001, 32'h52444E54, 1, OWN1, 3'b000, 3'b001));
        tbl.push_back(v(0, 1, 1, 3'b001, 32'h00000001, 1, OWN1, 3'b000, 3'b001));
        tbl.push_back(v(0, 1, 1, 3'b001, 32'h00000002, 1, OWN1, 3'b000, 3'b001));
        tbl.push_back(v(0, 1, 0, 3'b000, 32'h0,        0, OWN1, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 0, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));
        tbl.push_back(v(0, 1, 0, 3'b000, 32'h0,        1, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 0, 0, 3'b000, 32'h0,        0, OWN0, 3'b000, 3'b000));
        tbl.push_back(v(0, 0, 0, 3'b000, 32'h0,        0, NONE, 3'b000, 3'b000));

        foreach (tbl[i]) begin
            if (i != 0) step();
            rst = tbl[i].rst;
            set_req(tbl[i].r0, tbl[i].r1);
            {s_rty, s_err, s_ack} = tbl[i].term;
            s_rdat = tbl[i].sdat;
            #1;
            case (tbl[i].e_own)
                OWN0:    begin e_we = 1'b1; e_adr = M0_ADR; e_dat = M0_DAT; e_sel = M0_SEL; end
                OWN1:    begin e_we = 1'b0; e_adr = M1_ADR; e_dat = M1_DAT; e_sel = M1_SEL; end
                default: begin e_we = 1'b0; e_adr = '0;     e_dat = '0;     e_sel = '0;     end
            endcase
            chk($sformatf("row%0d s_cyc", i), {63'd0, s_cyc}, {63'd0, tbl[i].e_cyc});
            chk($sformatf("row%0d s_stb", i), {63'd0, s_stb}, {63'd0, tbl[i].e_cyc});
            chk($sformatf("row%0d s_we", i),  {63'd0, s_we},  {63'd0, e_we});
            chk($sformatf("row%0d s_adr", i), {44'd0, s_adr}, {44'd0, e_adr});
            chk($sformatf("row%0d s_dat", i), {32'd0, s_wdat}, {32'd0, e_dat});
            chk($sformatf("row%0d s_sel", i), {60'd0, s_sel}, {60'd0, e_sel});
            chk($sformatf("row%0d m0 rty/err/ack", i), {61'd0, m0_rty, m0_err, m0_ack}, {61'd0, tbl[i].e_t0});
            chk($sformatf("row%0d m1 rty/err/ack", i), {61'd0, m1_rty, m1_err, m1_ack}, {61'd0, tbl[i].e_t1});
            chk($sformatf("row%0d m0 rdat", i), {32'd0, m0_rdat}, {32'd0, tbl[i].sdat});
            chk($sformatf("row%0d m1 rdat", i), {32'd0, m1_rdat}, {32'd0, tbl[i].sdat});
            chk($sformatf("row%0d tcnt", i), {56'd0, tcnt}, 64'd0);
        end

        // Hung slave: 256 strobed cycles, one forced-error cycle, then fair re-arbitration,
        // followed by a reset while m1 owns the bus.
        do_reset();
        set_req(1'b1, 1'b0);
        s_rdat = 32'h0;
        early_err = 1'b0;
        for (int k = 1; k <= 264; k++) begin
            step();
            s_ack = (k == 257) || (k == 261);
            rst   = (k == 260);
            if (k == 258) set_req(1'b1, 1'b1);
            if (k == 263) set_req(1'b0, 1'b0);
            #1;
            if (k <= 256 && m0_err) early_err = 1'b1;
            if (k == 1) chk("tout first own s_cyc", {63'd0, s_cyc}, 64'd1);
            if (k == 256) begin
                chk("tout last stall s_stb", {63'd0, s_stb}, 64'd1);
                chk("tout last stall m0_err", {63'd0, m0_err}, 64'd0);
            end
            if (k == 257) begin
                chk("tout m0_err", {63'd0, m0_err}, 64'd1);
                chk("tout stray ack blocked", {63'd0, m0_ack}, 64'd0);
                chk("tout m1 err/ack", {62'd0, m1_err, m1_ack}, 64'd0);
                chk("tout s_cyc/s_stb", {62'd0, s_cyc, s_stb}, 64'd0);
                chk("tout tcnt during", {56'd0, tcnt}, 64'd0);
            end
            if (k == 258) begin
                chk("post tout idle s_cyc", {63'd0, s_cyc}, 64'd0);
                chk("post tout m0_err", {63'd0, m0_err}, 64'd0);
                chk("post tout tcnt", {56'd0, tcnt}, 64'd1);
            end
            if (k == 259) begin
                chk("post tout fair grant adr", {44'd0, s_adr}, {44'd0, M1_ADR});
                chk("post tout fair grant cyc", {63'd0, s_cyc}, 64'd1);
            end
            if (k == 260) begin
                chk("pre reset own1 stb", {63'd0, s_stb}, 64'd1);
                chk("pre reset tcnt", {56'd0, tcnt}, 64'd1);
            end
            if (k == 261) begin
                chk("mid reset s_cyc/s_stb", {62'd0, s_cyc, s_stb}, 64'd0);
                chk("mid reset acks", {62'd0, m0_ack, m1_ack}, 64'd0);
                chk("mid reset tcnt", {56'd0, tcnt}, 64'd0);
            end
            if (k == 262) begin
                chk("after reset grant adr", {44'd0, s_adr}, {44'd0, M0_ADR});
                chk("after reset grant cyc", {63'd0, s_cyc}, 64'd1);
            end
        end
        chk("tout no early err", {63'd0, early_err}, 64'd0);

        // Saturation on the short-timeout instance: one timeout every 5 cycles.
        do_reset();
        f_req = 1'b1;
        for (int k = 1; k <= 1500; k++) begin
            step();
            if (k == 5 || k == 50 || k == 1270 || k == 1275 || k == 1500) begin
                exp_cnt = (k / 5 > 255) ? 255 : k / 5;
                chk($sformatf("sat tcnt k=%0d", k), {56'd0, f_tcnt}, 64'(exp_cnt));
            end
        end
        f_req = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
